// File: rtl/parc_core_rob_ctrl.sv
// parc_core_rob_ctrl: reorder-buffer bookkeeping for the parc core.
// Tracks per-slot valid/filled/wen/waddr, allocates at the tail,
// retires in order from the head, and answers source-operand lookups
// against in-flight destinations.
// Optional feature macro: ROB_BYPASS_EN. When it is defined, a filled
// matching entry is offered as a bypass source. When it is undefined,
// any matching entry stalls the operand.
module parc_core_rob_ctrl #(
  parameter int ROB_SLOTS  = 16,
  parameter int ROB_SLOT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rob_alloc_val,
  output logic                  rob_alloc_rdy,
  output logic [ROB_SLOT_W-1:0] rob_alloc_slot,
  input  logic                  rob_alloc_wen,
  input  logic [4:0]            rob_alloc_waddr,
  input  logic                  rob_fill_val,
  input  logic [ROB_SLOT_W-1:0] rob_fill_slot,
  output logic                  rob_commit_val,
  output logic                  rob_commit_wen,
  output logic [ROB_SLOT_W-1:0] rob_commit_slot,
  output logic [4:0]            rob_commit_waddr,
  input  logic [4:0]            src0_addr,
  input  logic [4:0]            src1_addr,
  output logic                  src0_byp_val,
  output logic                  src1_byp_val,
  output logic [ROB_SLOT_W-1:0] src0_byp_slot,
  output logic [ROB_SLOT_W-1:0] src1_byp_slot,
  output logic                  src0_stall,
  output logic                  src1_stall
);

`ifdef ROB_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  localparam logic [ROB_SLOT_W:0] FULL_CNT = (ROB_SLOT_W+1)'(ROB_SLOTS);
  localparam logic [ROB_SLOT_W-1:0] PTR_ONE = ROB_SLOT_W'(1);

  logic [ROB_SLOTS-1:0]  valid_q, valid_d;
  logic [ROB_SLOTS-1:0]  filled_q, filled_d;
  logic [ROB_SLOTS-1:0]  wen_q, wen_d;
  logic [4:0]            waddr_q [ROB_SLOTS];
  logic [4:0]            waddr_d [ROB_SLOTS];
  logic [ROB_SLOT_W-1:0] head_q, head_d;
  logic [ROB_SLOT_W-1:0] tail_q, tail_d;
  logic [ROB_SLOT_W:0]   count_q, count_d;

  logic                  alloc_fire;
  logic                  commit_fire;

  logic                  src0_hit, src0_rdy;
  logic                  src1_hit, src1_rdy;
  logic [ROB_SLOT_W-1:0] src0_idx, src1_idx;
  logic [ROB_SLOT_W-1:0] scan_idx;

  // Free-slot indication comes from registered count only, so a commit in
  // the same cycle never opens a slot for a same-cycle allocation.
  assign rob_alloc_rdy  = (count_q != FULL_CNT);
  assign rob_alloc_slot = tail_q;
  assign alloc_fire     = rob_alloc_val && rob_alloc_rdy;

  // Filled is a registered bit, so a fill can retire no earlier than the
  // following cycle.
  assign commit_fire      = valid_q[head_q] && filled_q[head_q];
  assign rob_commit_val   = commit_fire;
  assign rob_commit_wen   = commit_fire && wen_q[head_q] && (waddr_q[head_q] != 5'd0);
  assign rob_commit_slot  = head_q;
  assign rob_commit_waddr = valid_q[head_q] ? waddr_q[head_q] : 5'd0;

  // Next-state for entries and pointers: fill, then retire head, then allocate tail.
  always_comb begin
    valid_d  = valid_q;
    filled_d = filled_q;
    wen_d    = wen_q;
    waddr_d  = waddr_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;

    if (rob_fill_val && valid_q[rob_fill_slot]) begin
      filled_d[rob_fill_slot] = 1'b1;
    end

    if (commit_fire) begin
      valid_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
      wen_d[head_q]    = 1'b0;
      waddr_d[head_q]  = 5'd0;
      head_d           = head_q + PTR_ONE;
    end

    // The tail slot is never the committing head: a full buffer refuses allocation,
    // and an empty buffer has no valid head.
    if (alloc_fire) begin
      valid_d[tail_q]  = 1'b1;
      filled_d[tail_q] = 1'b0;
      wen_d[tail_q]    = rob_alloc_wen;
      waddr_d[tail_q]  = rob_alloc_waddr;
      tail_d           = tail_q + PTR_ONE;
    end

    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entry and pointer registers. Reset discards every in-flight entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      filled_q <= '0;
      wen_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < ROB_SLOTS; i++) begin
        waddr_q[i] <= 5'd0;
      end
    end else begin
      valid_q  <= valid_d;
      filled_q <= filled_d;
      wen_q    <= wen_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      waddr_q  <= waddr_d;
    end
  end

  // Source lookup: walk from oldest (head) to youngest so the last hit wins.
  // The retiring head still counts, because its regfile write lands at the
  // clock edge and is not yet visible to decode.
  always_comb begin
    src0_hit = 1'b0;
    src0_rdy = 1'b0;
    src0_idx = '0;
    src1_hit = 1'b0;
    src1_rdy = 1'b0;
    src1_idx = '0;
    scan_idx = '0;
    for (int i = 0; i < ROB_SLOTS; i++) begin
      scan_idx = head_q + ROB_SLOT_W'(i);
      if (valid_q[scan_idx] && wen_q[scan_idx]) begin
        if ((src0_addr != 5'd0) && (waddr_q[scan_idx] == src0_addr)) begin
          src0_hit = 1'b1;
          src0_rdy = filled_q[scan_idx];
          src0_idx = scan_idx;
        end
        if ((src1_addr != 5'd0) && (waddr_q[scan_idx] == src1_addr)) begin
          src1_hit = 1'b1;
          src1_rdy = filled_q[scan_idx];
          src1_idx = scan_idx;
        end
      end
    end
  end

  // Without bypass every hit stalls; with bypass only unfilled hits stall.
  assign src0_byp_val  = BYP_EN && src0_hit && src0_rdy;
  assign src1_byp_val  = BYP_EN && src1_hit && src1_rdy;
  assign src0_stall    = src0_hit && !(BYP_EN && src0_rdy);
  assign src1_stall    = src1_hit && !(BYP_EN && src1_rdy);
  assign src0_byp_slot = src0_byp_val ? src0_idx : '0;
  assign src1_byp_slot = src1_byp_val ? src1_idx : '0;

endmodule

// File: tb/tb_parc_core_rob_ctrl.sv
// Testbench for parc_core_rob_ctrl: directed stimulus, commit scoreboard.
module tb_parc_core_rob_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rob_alloc_val = 1'b0;
  logic       rob_alloc_rdy;
  logic [3:0] rob_alloc_slot;
  logic       rob_alloc_wen = 1'b0;
  logic [4:0] rob_alloc_waddr = 5'd0;
  logic       rob_fill_val = 1'b0;
  logic [3:0] rob_fill_slot = 4'd0;
  logic       rob_commit_val;
  logic       rob_commit_wen;
  logic [3:0] rob_commit_slot;
  logic [4:0] rob_commit_waddr;
  logic [4:0] src0_addr = 5'd0;
  logic [4:0] src1_addr = 5'd0;
  logic       src0_byp_val, src1_byp_val;
  logic [3:0] src0_byp_slot, src1_byp_slot;
  logic       src0_stall, src1_stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] slot;
    logic       wen;
    logic [4:0] waddr;
  } commit_t;

  commit_t exp_q[$];

`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  parc_core_rob_ctrl #(.ROB_SLOTS(16), .ROB_SLOT_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .rob_alloc_val    (rob_alloc_val),
    .rob_alloc_rdy    (rob_alloc_rdy),
    .rob_alloc_slot   (rob_alloc_slot),
    .rob_alloc_wen    (rob_alloc_wen),
    .rob_alloc_waddr  (rob_alloc_waddr),
    .rob_fill_val     (rob_fill_val),
    .rob_fill_slot    (rob_fill_slot),
    .rob_commit_val   (rob_commit_val),
    .rob_commit_wen   (rob_commit_wen),
    .rob_commit_slot  (rob_commit_slot),
    .rob_commit_waddr (rob_commit_waddr),
    .src0_addr        (src0_addr),
    .src1_addr        (src1_addr),
    .src0_byp_val     (src0_byp_val),
    .src1_byp_val     (src1_byp_val),
    .src0_byp_slot    (src0_byp_slot),
    .src1_byp_slot    (src1_byp_slot),
    .src0_stall       (src0_stall),
    .src1_stall       (src1_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every retirement must match the oldest expected commit.
  always @(negedge clk) begin
    if (!reset && rob_commit_val) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit_slot", int'(rob_commit_slot), -1);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        chk("mon_commit_slot",  int'(rob_commit_slot),  int'(e.slot));
        chk("mon_commit_wen",   int'(rob_commit_wen),   int'(e.wen));
        chk("mon_commit_waddr", int'(rob_commit_waddr), int'(e.waddr));
      end
    end
  end

  task automatic push_commit(input int s, input bit w, input int a);
    commit_t e;
    e.slot  = 4'(s);
    e.wen   = w;
    e.waddr = 5'(a);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_alloc_rdy", int'(rob_alloc_rdy), 1);
    chk("rst_commit_val", int'(rob_commit_val), 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic do_alloc(input bit w, input int a, input int exp_slot);
    rob_alloc_val   = 1'b1;
    rob_alloc_wen   = w;
    rob_alloc_waddr = 5'(a);
    @(negedge clk);
    chk("alloc_rdy", int'(rob_alloc_rdy), 1);
    chk("alloc_slot", int'(rob_alloc_slot), exp_slot);
    tick();
    rob_alloc_val   = 1'b0;
    rob_alloc_wen   = 1'b0;
    rob_alloc_waddr = 5'd0;
  endtask

  task automatic do_fill(input int s);
    rob_fill_val  = 1'b1;
    rob_fill_slot = 4'(s);
    tick();
    rob_fill_val  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst0_alloc_rdy", int'(rob_alloc_rdy), 1);
    chk("rst0_alloc_slot", int'(rob_alloc_slot), 0);
    chk("rst0_commit_val", int'(rob_commit_val), 0);
    chk("rst0_commit_wen", int'(rob_commit_wen), 0);
    chk("rst0_commit_slot", int'(rob_commit_slot), 0);
    chk("rst0_commit_waddr", int'(rob_commit_waddr), 0);
    chk("rst0_src0_stall", int'(src0_stall), 0);
    chk("rst0_src0_byp", int'(src0_byp_val), 0);
    chk("rst0_src1_byp_slot", int'(src1_byp_slot), 0);
    tick();
    tick();
    reset = 1'b0;

    // Fill the buffer: slots 0..15 in order, waddr = slot+1
    for (int i = 0; i < 16; i++) do_alloc(1'b1, i + 1, i);
    @(negedge clk);
    chk("full_alloc_rdy", int'(rob_alloc_rdy), 0);
    chk("full_tail_wrap", int'(rob_alloc_slot), 0);
    rob_alloc_val = 1'b1;
    rob_alloc_waddr = 5'd30;
    tick();
    rob_alloc_val = 1'b0;
    @(negedge clk);
    chk("full_17th_rejected_slot", int'(rob_alloc_slot), 0);
    chk("full_17th_rejected_rdy", int'(rob_alloc_rdy), 0);
    src0_addr = 5'd5;
    src1_addr = 5'd0;
    #1;
    chk("full_src0_stall_unfilled", int'(src0_stall), 1);
    chk("full_src0_byp", int'(src0_byp_val), 0);
    chk("full_src1_zero_stall", int'(src1_stall), 0);
    src0_addr = 5'd16;
    src1_addr = 5'd20;
    #1;
    chk("full_src0_youngest_stall", int'(src0_stall), 1);
    chk("full_src1_nomatch_stall", int'(src1_stall), 0);
    tick();

    // Full buffer, head filled, alloc pending: commit first, alloc next
    push_commit(0, 1'b1, 1);
    do_fill(0);
    rob_alloc_val = 1'b1;
    rob_alloc_wen = 1'b1;
    rob_alloc_waddr = 5'd9;
    src0_addr = 5'd1;
    @(negedge clk);
    chk("fullc_commit_val", int'(rob_commit_val), 1);
    chk("fullc_alloc_rdy", int'(rob_alloc_rdy), 0);
    chk("fullc_retire_stall", int'(src0_stall), BYP ? 0 : 1);
    chk("fullc_retire_byp", int'(src0_byp_val), BYP ? 1 : 0);
    chk("fullc_retire_byp_slot", int'(src0_byp_slot), 0);
    tick();
    @(negedge clk);
    chk("fullc_next_rdy", int'(rob_alloc_rdy), 1);
    chk("fullc_next_slot", int'(rob_alloc_slot), 0);
    chk("fullc_next_commit", int'(rob_commit_val), 0);
    tick();
    rob_alloc_val = 1'b0;
    @(negedge clk);
    chk("fullc_wrap_rdy", int'(rob_alloc_rdy), 0);
    chk("fullc_wrap_tail", int'(rob_alloc_slot), 1);
    tick();
    chk("q_empty_a", exp_q.size(), 0);
    src0_addr = 5'd0;
    src1_addr = 5'd0;
    do_reset();

    // Single alloc, fill in cycle N, commit in N+1
    do_alloc(1'b1, 5, 0);
    src0_addr = 5'd5;
    rob_fill_val = 1'b1;
    rob_fill_slot = 4'd0;
    @(negedge clk);
    chk("fill_same_cycle_commit", int'(rob_commit_val), 0);
    chk("fill_same_cycle_stall", int'(src0_stall), 1);
    push_commit(0, 1'b1, 5);
    tick();
    rob_fill_val = 1'b0;
    @(negedge clk);
    chk("n1_commit_val", int'(rob_commit_val), 1);
    chk("n1_commit_wen", int'(rob_commit_wen), 1);
    chk("n1_commit_slot", int'(rob_commit_slot), 0);
    chk("n1_commit_waddr", int'(rob_commit_waddr), 5);
    chk("n1_retire_stall", int'(src0_stall), BYP ? 0 : 1);
    chk("n1_retire_byp", int'(src0_byp_val), BYP ? 1 : 0);
    tick();
    @(negedge clk);
    chk("n2_commit_val", int'(rob_commit_val), 0);
    chk("n2_alloc_rdy", int'(rob_alloc_rdy), 1);
    chk("n2_alloc_slot", int'(rob_alloc_slot), 1);
    chk("n2_src0_stall", int'(src0_stall), 0);
    src0_addr = 5'd0;
    tick();

    // wen=1 with waddr=0 must not write the regfile
    do_alloc(1'b1, 0, 1);
    push_commit(1, 1'b0, 0);
    do_fill(1);
    @(negedge clk);
    chk("r0_commit_val", int'(rob_commit_val), 1);
    chk("r0_commit_wen", int'(rob_commit_wen), 0);
    tick();

    // Out-of-order fills retire in order
    do_alloc(1'b1, 3, 2);
    do_alloc(1'b0, 4, 3);
    do_fill(3);
    @(negedge clk);
    chk("ooo_no_commit", int'(rob_commit_val), 0);
    tick();
    push_commit(2, 1'b1, 3);
    push_commit(3, 1'b0, 4);
    do_fill(2);
    @(negedge clk);
    chk("ooo_commit0_slot", int'(rob_commit_slot), 2);
    chk("ooo_commit0_val", int'(rob_commit_val), 1);
    tick();
    @(negedge clk);
    chk("ooo_commit1_slot", int'(rob_commit_slot), 3);
    chk("ooo_commit1_val", int'(rob_commit_val), 1);
    chk("ooo_commit1_wen", int'(rob_commit_wen), 0);
    tick();
    @(negedge clk);
    chk("ooo_drained", int'(rob_commit_val), 0);
    tick();

    // Fill to an invalid slot is ignored
    do_fill(4);
    do_alloc(1'b1, 8, 4);
    @(negedge clk);
    chk("inv_fill_no_commit", int'(rob_commit_val), 0);
    tick();
    chk("q_empty_b", exp_q.size(), 0);
    do_reset();

    // Youngest-match selection: slots 2 and 3 both write r7
    do_alloc(1'b1, 1, 0);
    do_alloc(1'b0, 7, 1);
    do_alloc(1'b1, 7, 2);
    do_alloc(1'b1, 7, 3);
    src0_addr = 5'd7;
    src1_addr = 5'd7;
    do_fill(2);
    @(negedge clk);
    chk("yng_unfilled_stall", int'(src0_stall), 1);
    chk("yng_unfilled_byp", int'(src0_byp_val), 0);
    tick();
    do_fill(3);
    @(negedge clk);
    chk("yng_src0_stall", int'(src0_stall), BYP ? 0 : 1);
    chk("yng_src0_byp", int'(src0_byp_val), BYP ? 1 : 0);
    chk("yng_src0_byp_slot", int'(src0_byp_slot), BYP ? 3 : 0);
    chk("yng_src1_stall", int'(src1_stall), BYP ? 0 : 1);
    chk("yng_src1_byp_slot", int'(src1_byp_slot), BYP ? 3 : 0);
    chk("yng_head_blocked", int'(rob_commit_val), 0);
    src0_addr = 5'd0;
    #1;
    chk("yng_r0_stall", int'(src0_stall), 0);
    chk("yng_r0_byp", int'(src0_byp_val), 0);
    src1_addr = 5'd0;
    tick();
    push_commit(0, 1'b1, 1);
    push_commit(1, 1'b0, 7);
    push_commit(2, 1'b1, 7);
    push_commit(3, 1'b1, 7);
    do_fill(1);
    do_fill(0);
    repeat (4) tick();
    @(negedge clk);
    chk("drain_done", int'(rob_commit_val), 0);
    chk("q_empty_c", exp_q.size(), 0);
    tick();

    // Asynchronous reset with five entries pending
    src0_addr = 5'd11;
    do_alloc(1'b1, 11, 4);
    do_alloc(1'b1, 12, 5);
    do_alloc(1'b1, 13, 6);
    do_alloc(1'b1, 14, 7);
    do_alloc(1'b1, 11, 8);
    do_fill(6);
    @(negedge clk);
    chk("pre_rst_stall", int'(src0_stall), 1);
    chk("pre_rst_rdy", int'(rob_alloc_slot), 9);
    tick();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_alloc_rdy", int'(rob_alloc_rdy), 1);
    chk("arst_alloc_slot", int'(rob_alloc_slot), 0);
    chk("arst_commit_val", int'(rob_commit_val), 0);
    chk("arst_commit_slot", int'(rob_commit_slot), 0);
    chk("arst_commit_waddr", int'(rob_commit_waddr), 0);
    chk("arst_src0_stall", int'(src0_stall), 0);
    chk("arst_src0_byp", int'(src0_byp_val), 0);
    tick();
    reset = 1'b0;
    do_alloc(1'b1, 11, 0);
    @(negedge clk);
    chk("post_rst_stall", int'(src0_stall), 1);
    chk("post_rst_commit", int'(rob_commit_val), 0);
    tick();
    chk("q_empty_final", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
